// File: rtl/uncached_axi_bridge.sv
// Uncached bridge: one data-bus access -> one single-beat AXI3 transaction.
// Ports: req_* uncached request/response pair; ar/r/aw/w/b AXI3 master channels.
module uncached_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [DATA_W/8-1:0] req_strobe,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_addr_ok,
  output logic              req_data_ok,
  output logic [DATA_W-1:0] req_rdata,
  output logic              req_err,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [3:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [1:0]        arlock,
  output logic [3:0]        arcache,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic [3:0]        awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [3:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic [1:0]        awlock,
  output logic [3:0]        awcache,
  output logic [2:0]        awprot,
  output logic              awvalid,
  input  logic              awready,
  output logic [3:0]        wid,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0]   lat_addr;
  logic [1:0]          lat_size;
  logic [DATA_W/8-1:0] lat_strb;
  logic [DATA_W-1:0]   lat_wdata;
  logic                aw_pending;
  logic                w_pending;
  logic                aw_done;
  logic                w_done;

  // Exactly one R beat is expected, so rlast carries no information.
  logic unused_rlast;
  assign unused_rlast = rlast;

  assign req_addr_ok = (state == IDLE) & req_valid & ~reset;

  assign arid    = AXI_ID;
  assign araddr  = lat_addr;
  assign arlen   = 4'd0;
  assign arsize  = {1'b0, lat_size};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = (state == RD_ADDR);
  assign rready  = (state == RD_DATA);

  assign awid    = AXI_ID;
  assign awaddr  = lat_addr;
  assign awlen   = 4'd0;
  assign awsize  = {1'b0, lat_size};
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awvalid = (state == WR_REQ) & aw_pending;

  assign wid     = AXI_ID;
  assign wdata   = lat_wdata;
  assign wstrb   = lat_strb;
  assign wlast   = 1'b1;
  assign wvalid  = (state == WR_REQ) & w_pending;
  assign bready  = (state == WR_RESP);

  // A channel counts as done if already handshaken or handshaking now.
  assign aw_done = ~aw_pending | awready;
  assign w_done  = ~w_pending | wready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (req_addr_ok)
          state_nx = req_write ? WR_REQ : RD_ADDR;
      end
      RD_ADDR: begin
        if (arready) state_nx = RD_DATA;
      end
      RD_DATA: begin
        if (rvalid) state_nx = IDLE;
      end
      WR_REQ: begin
        if (aw_done && w_done) state_nx = WR_RESP;
      end
      WR_RESP: begin
        if (bvalid) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lat_addr    <= '0;
      lat_size    <= '0;
      lat_strb    <= '0;
      lat_wdata   <= '0;
      aw_pending  <= 1'b0;
      w_pending   <= 1'b0;
      req_data_ok <= 1'b0;
      req_rdata   <= '0;
      req_err     <= 1'b0;
    end else begin
      req_data_ok <= 1'b0;
      if (req_addr_ok) begin
        lat_addr   <= req_addr;
        lat_size   <= (req_size == 2'd3) ? 2'd2 : req_size;
        lat_strb   <= req_strobe;
        lat_wdata  <= req_wdata;
        aw_pending <= req_write;
        w_pending  <= req_write;
      end
      if (awvalid && awready) aw_pending <= 1'b0;
      if (wvalid && wready)   w_pending  <= 1'b0;
      if (rready && rvalid) begin
        req_rdata   <= rdata;
        req_err     <= |rresp;
        req_data_ok <= 1'b1;
      end
      if (bready && bvalid) begin
        req_err     <= |bresp;
        req_data_ok <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uncached_axi_bridge.sv
// Directed bench for uncached_axi_bridge.
// Drives a hand-scripted AXI slave and checks against hand-computed values.
module tb_uncached_axi_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic [3:0]  req_strobe;
  logic [31:0] req_wdata;
  logic        req_addr_ok, req_data_ok, req_err;
  logic [31:0] req_rdata;
  logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready;
  logic [3:0]  wstrb;
  logic        bvalid, bready;

  int total = 0;
  int bad = 0;
  int oks;

  always #5 clk = ~clk;

  uncached_axi_bridge dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size),
    .req_strobe(req_strobe), .req_wdata(req_wdata),
    .req_addr_ok(req_addr_ok), .req_data_ok(req_data_ok),
    .req_rdata(req_rdata), .req_err(req_err),
    .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb),
    .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_arv"}, 32'(arvalid), 0);
    chk({tag, "_rrdy"}, 32'(rready), 0);
    chk({tag, "_awv"}, 32'(awvalid), 0);
    chk({tag, "_wv"}, 32'(wvalid), 0);
    chk({tag, "_brdy"}, 32'(bready), 0);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 0; req_write = 0; req_addr = 0;
    req_size = 0; req_strobe = 0; req_wdata = 0;
    arready = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    awready = 0; wready = 0; bresp = 0; bvalid = 0;
    tick(); tick();
    idle_chk("rst");
    chk("rst_dok", 32'(req_data_ok), 0);
    chk("rst_err", 32'(req_err), 0);
    chk("rst_araddr", araddr, 0);
    reset = 1'b0;

    // Load word, zero-wait slave
    req_valid = 1; req_write = 0;
    req_addr = 32'h1FAF_F000; req_size = 2;
    #1 chk("ld_aok", 32'(req_addr_ok), 1);
    tick();
    req_valid = 0; arready = 1;
    chk("ld_arv", 32'(arvalid), 1);
    chk("ld_araddr", araddr, 32'h1FAF_F000);
    chk("ld_arsize", 32'(arsize), 2);
    chk("ld_arlen", 32'(arlen), 0);
    chk("ld_arburst", 32'(arburst), 1);
    chk("ld_arid", 32'(arid), 1);
    tick();
    arready = 0; rvalid = 1; rdata = 32'hDEAD_BEEF; rresp = 0;
    chk("ld_arv_off", 32'(arvalid), 0);
    chk("ld_rrdy", 32'(rready), 1);
    tick();
    rvalid = 0;
    chk("ld_dok", 32'(req_data_ok), 1);
    chk("ld_rdata", req_rdata, 32'hDEAD_BEEF);
    chk("ld_err", 32'(req_err), 0);
    idle_chk("ld_end");
    tick();
    chk("ld_dok_pulse", 32'(req_data_ok), 0);

    // Store byte, awready late, wready immediate
    req_valid = 1; req_write = 1; req_addr = 32'h1FAF_F003;
    req_size = 0; req_strobe = 4'b1000; req_wdata = 32'hAB00_0000;
    tick();
    req_valid = 0; req_write = 0; wready = 1;
    chk("st_awv1", 32'(awvalid), 1);
    chk("st_wv1", 32'(wvalid), 1);
    chk("st_wlast", 32'(wlast), 1);
    chk("st_wstrb", 32'(wstrb), 4'b1000);
    chk("st_wdata", wdata, 32'hAB00_0000);
    chk("st_awaddr", awaddr, 32'h1FAF_F003);
    chk("st_awsize", 32'(awsize), 0);
    tick();
    wready = 0;
    chk("st_wv2", 32'(wvalid), 0);
    chk("st_awv2", 32'(awvalid), 1);
    tick();
    chk("st_awv3", 32'(awvalid), 1);
    tick();
    awready = 1;
    chk("st_awv4", 32'(awvalid), 1);
    chk("st_brdy_early", 32'(bready), 0);
    tick();
    awready = 0;
    chk("st_awv_off", 32'(awvalid), 0);
    chk("st_brdy", 32'(bready), 1);
    chk("st_dok_early", 32'(req_data_ok), 0);
    bvalid = 1; bresp = 0;
    tick();
    bvalid = 0;
    chk("st_dok", 32'(req_data_ok), 1);
    chk("st_err", 32'(req_err), 0);
    idle_chk("st_end");
    tick();

    // arready delayed while req inputs wander
    req_valid = 1; req_write = 0; req_addr = 32'h1000_0010; req_size = 1;
    tick();
    oks = 0;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1; req_addr = 32'h2000_0000 + 32'(i * 4);
      req_size = 2'(i);
      #1;
      if (req_addr_ok) oks++;
      chk("dly_arv", 32'(arvalid), 1);
      chk("dly_araddr", araddr, 32'h1000_0010);
      tick();
    end
    chk("dly_no_aok", 32'(oks), 0);
    chk("dly_arsize", 32'(arsize), 1);
    req_valid = 0; arready = 1;
    tick();
    arready = 0; rvalid = 1; rdata = 32'h1234_5678;
    tick();
    rvalid = 0;
    oks = 0;
    chk("dly_rdata", req_rdata, 32'h1234_5678);
    for (int i = 0; i < 4; i++) begin
      if (req_data_ok) oks++;
      tick();
    end
    chk("dly_one_dok", 32'(oks), 1);

    // SLVERR load, then back-to-back load in the data_ok cycle
    req_valid = 1; req_addr = 32'h0000_0100; req_size = 2;
    tick();
    req_valid = 0; arready = 1;
    tick();
    arready = 0; rvalid = 1; rdata = 32'h0BAD_0BAD; rresp = 2'b10;
    tick();
    rvalid = 0; rresp = 0;
    req_valid = 1; req_addr = 32'h0000_0200;
    chk("err_dok", 32'(req_data_ok), 1);
    chk("err_flag", 32'(req_err), 1);
    #1 chk("b2b_aok", 32'(req_addr_ok), 1);
    tick();
    req_valid = 0; arready = 1;
    chk("b2b_araddr", araddr, 32'h0000_0200);
    tick();
    arready = 0; rvalid = 1; rdata = 32'h5555_AAAA;
    tick();
    rvalid = 0;
    chk("b2b_dok", 32'(req_data_ok), 1);
    chk("b2b_err", 32'(req_err), 0);
    chk("b2b_rdata", req_rdata, 32'h5555_AAAA);
    tick();

    // Reset in RD_DATA, then size=3 load
    req_valid = 1; req_addr = 32'h0000_0300; req_size = 2;
    tick();
    req_valid = 0; arready = 1;
    tick();
    arready = 0;
    chk("rs_rrdy", 32'(rready), 1);
    reset = 1;
    tick();
    reset = 0;
    idle_chk("rs");
    chk("rs_dok", 32'(req_data_ok), 0);
    chk("rs_araddr", araddr, 0);
    req_valid = 1; req_addr = 32'h0000_0400; req_size = 3;
    #1 chk("rs_aok", 32'(req_addr_ok), 1);
    tick();
    req_valid = 0; arready = 1;
    chk("sz3_arsize", 32'(arsize), 3'b010);
    chk("sz3_araddr", araddr, 32'h0000_0400);
    tick();
    arready = 0; rvalid = 1; rdata = 32'hCAFE_F00D;
    tick();
    rvalid = 0;
    chk("sz3_dok", 32'(req_data_ok), 1);
    chk("sz3_rdata", req_rdata, 32'hCAFE_F00D);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
